// File: rtl/lshifdown_rx_filter_pkg.sv
// Package shared by the lshifdown receive-filter slice.
//   LSHIFT_IDLE   : resolved level of an idle (floating, pulled-up) line
//   clog2()       : ceiling log2, used to size the per-line filter counter
//   params_legal(): legal-range check on SYNC_STAGES / FILT_CYCLES
package lshifdown_rx_filter_pkg;

  // An lshifdown output only ever pulls low; the pull-up resolves the float to 1.
  localparam logic LSHIFT_IDLE = 1'b1;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int FILT_CYCLES_MIN = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic bit params_legal(input int sync_stages, input int filt_cycles);
    return (sync_stages >= SYNC_STAGES_MIN) && (sync_stages <= SYNC_STAGES_MAX) &&
           (filt_cycles >= FILT_CYCLES_MIN);
  endfunction

endpackage

// File: rtl/lshifdown_rx_filter_if.sv
// Interface bundling the receive-filter bus.
//   a        : resolved lshifdown lines (asynchronous to clk)
//   y        : filtered level per line
//   rose/fell: one-cycle edge pulses on y
//   evt_*    : sticky change-event record and its acknowledge
// modport slave is used by the filter; modport master by whoever drives the lines.
interface lshifdown_rx_filter_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] rose;
  logic [WIDTH-1:0] fell;
  logic [WIDTH-1:0] evt_mask;
  logic             evt_vld;
  logic             evt_ovf;
  logic             evt_ack;

  modport master (
    output a, evt_ack,
    input  y, rose, fell, evt_mask, evt_vld, evt_ovf
  );

  modport slave (
    input  a, evt_ack,
    output y, rose, fell, evt_mask, evt_vld, evt_ovf
  );
endinterface

// File: rtl/lshifdown_rx_filter_bit_filter.sv
// One receive line: synchronizer chain, persistence filter and edge pulses.
//   clk   : core clock
//   rst_n : asynchronous active-low reset
//   a     : raw resolved line, asynchronous to clk
//   y     : filtered level (idle 1)
//   rose  : one-cycle pulse, y went 0->1
//   fell  : one-cycle pulse, y went 1->0
//   chg   : y updates on the coming edge (feeds the event record in the top)
// A new synchronized level must be seen on FILT_CYCLES consecutive edges
// before y takes it; any return to the current y restarts the count.
module lshifdown_rx_filter_bit_filter
  import lshifdown_rx_filter_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  output logic y,
  output logic rose,
  output logic fell,
  output logic chg
);

  localparam int CNT_W = clog2(FILT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [CNT_W-1:0]       cnt_next;
  logic                   y_reg;
  logic                   y_next;
  logic                   rose_reg;
  logic                   fell_reg;
  logic                   s;

  assign s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= {SYNC_STAGES{LSHIFT_IDLE}};
      cnt_reg  <= '0;
      y_reg    <= LSHIFT_IDLE;
      rose_reg <= 1'b0;
      fell_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], a};
      cnt_reg  <= cnt_next;
      y_reg    <= y_next;
      // On an update y_next equals s, so s gives the direction of the change.
      rose_reg <= chg & s;
      fell_reg <= chg & ~s;
    end
  end

  always_comb begin
    cnt_next = cnt_reg;
    y_next   = y_reg;
    if (s == y_reg) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_LAST) begin
      y_next   = s;
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  assign chg  = (y_next != y_reg);
  assign y    = y_reg;
  assign rose = rose_reg;
  assign fell = fell_reg;

endmodule

// File: rtl/lshifdown_rx_filter.sv
// Receive stage behind the lshifdown level shifters.
//   clk   : core clock, all flops rising-edge
//   rst_n : asynchronous active-low reset
//   bus   : lshifdown_rx_filter_if.slave (a, evt_ack in; y, rose, fell,
//           evt_vld, evt_mask, evt_ovf out)
// WIDTH independent lines are each filtered by a bit-filter instance; this
// level only keeps the sticky event record (mask of changed lines plus an
// overflow flag for a line that changed again before being acknowledged).
module lshifdown_rx_filter
  import lshifdown_rx_filter_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lshifdown_rx_filter_if.slave  bus
);

  if (!params_legal(SYNC_STAGES, FILT_CYCLES)) begin : g_param_error
    $error("lshifdown_rx_filter: SYNC_STAGES must be 2..4 and FILT_CYCLES >= 1");
  end

  logic [WIDTH-1:0] y_w;
  logic [WIDTH-1:0] rose_w;
  logic [WIDTH-1:0] fell_w;
  logic [WIDTH-1:0] chg_w;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_line
    lshifdown_rx_filter_bit_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CYCLES (FILT_CYCLES)
    ) u_bit_filter (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (bus.a[gi]),
      .y     (y_w[gi]),
      .rose  (rose_w[gi]),
      .fell  (fell_w[gi]),
      .chg   (chg_w[gi])
    );
  end

  logic [WIDTH-1:0] evt_mask_reg;
  logic [WIDTH-1:0] evt_mask_next;
  logic             evt_ovf_reg;
  logic             evt_ovf_next;
  logic             evt_vld;
  logic             ack_ok;

  // Valid is a pure function of the registered mask, so no path from a.
  assign evt_vld = |evt_mask_reg;
  assign ack_ok  = bus.evt_ack & evt_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_mask_reg <= '0;
      evt_ovf_reg  <= 1'b0;
    end else begin
      evt_mask_reg <= evt_mask_next;
      evt_ovf_reg  <= evt_ovf_next;
    end
  end

  // A change landing on the acknowledge edge seeds the new mask rather than
  // being cleared with the old one.
  always_comb begin
    evt_mask_next = evt_mask_reg | chg_w;
    evt_ovf_next  = evt_ovf_reg | (|(evt_mask_reg & chg_w));
    if (ack_ok) begin
      evt_mask_next = chg_w;
      evt_ovf_next  = 1'b0;
    end
  end

  assign bus.y        = y_w;
  assign bus.rose     = rose_w;
  assign bus.fell     = fell_w;
  assign bus.evt_mask = evt_mask_reg;
  assign bus.evt_vld  = evt_vld;
  assign bus.evt_ovf  = evt_ovf_reg;

endmodule

// File: tb/tb_lshifdown_rx_filter.sv
// Self-checking bench for lshifdown_rx_filter: directed scenarios with
// fixed expectations, then randomized traffic against a history-window model.
module tb_lshifdown_rx_filter;

  localparam int WIDTH  = 4;
  localparam int SYNC   = 2;
  localparam int FILT   = 4;
  localparam int LAT    = SYNC + FILT;
  localparam int HDEPTH = SYNC + FILT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  lshifdown_rx_filter_if #(.WIDTH(WIDTH)) bus ();

  lshifdown_rx_filter #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC),
    .FILT_CYCLES (FILT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: hist[k] holds the line values sampled k+1 edges ago.
  // A line's filtered level flips on an edge when every one of the last
  // FILT synchronized samples (sample delayed by SYNC edges) differs from it.
  logic [WIDTH-1:0] hist [0:HDEPTH-1];
  logic [WIDTH-1:0] m_y, m_rose, m_fell, m_mask;
  logic             m_ovf;

  function automatic logic [WIDTH-1:0] model_chg();
    logic [WIDTH-1:0] r;
    bit all_diff;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      all_diff = 1'b1;
      for (int j = 0; j < FILT; j++) begin
        if (hist[SYNC-1+j][i] == m_y[i]) all_diff = 1'b0;
      end
      r[i] = all_diff;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < HDEPTH; k++) hist[k] <= '1;
      m_y    <= '1;
      m_rose <= '0;
      m_fell <= '0;
      m_mask <= '0;
      m_ovf  <= 1'b0;
    end else begin
      for (int k = 1; k < HDEPTH; k++) hist[k] <= hist[k-1];
      hist[0] <= bus.a;
      m_y    <= m_y ^ model_chg();
      m_rose <= model_chg() & ~m_y;
      m_fell <= model_chg() & m_y;
      if (bus.evt_ack && (m_mask != '0)) begin
        m_mask <= model_chg();
        m_ovf  <= 1'b0;
      end else begin
        m_mask <= m_mask | model_chg();
        m_ovf  <= m_ovf | (|(m_mask & model_chg()));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic ack_pulse();
    bus.evt_ack = 1'b1;
    tick(1);
    bus.evt_ack = 1'b0;
  endtask

  task automatic test_reset();
    bus.a = 4'($urandom);
    rst_n = 1'b0;
    tick(2);
    checks++; if (bus.y !== 4'hF) begin failures++; $display("FAIL reset_y: got %h expected %h", bus.y, 4'hF); end
    checks++; if (bus.rose !== 4'h0) begin failures++; $display("FAIL reset_rose: got %h expected %h", bus.rose, 4'h0); end
    checks++; if (bus.fell !== 4'h0) begin failures++; $display("FAIL reset_fell: got %h expected %h", bus.fell, 4'h0); end
    checks++; if (bus.evt_mask !== 4'h0) begin failures++; $display("FAIL reset_mask: got %h expected %h", bus.evt_mask, 4'h0); end
    checks++; if (bus.evt_vld !== 1'b0) begin failures++; $display("FAIL reset_vld: got %b expected 0", bus.evt_vld); end
    checks++; if (bus.evt_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 0", bus.evt_ovf); end
    bus.a = '1;
    rst_n = 1'b1;
    #1;
    checks++; if (bus.y !== 4'hF) begin failures++; $display("FAIL release_y: got %h expected %h", bus.y, 4'hF); end
    checks++; if ({bus.evt_mask, bus.evt_vld, bus.evt_ovf} !== 6'b0) begin failures++; $display("FAIL release_evt: got %b expected 000000", {bus.evt_mask, bus.evt_vld, bus.evt_ovf}); end
    @(negedge clk);
    tick(LAT + 2);
    $display("test_reset done checks=%0d", checks);
  endtask

  task automatic test_latency();
    bus.a[0] = 1'b0;
    tick(LAT - 1);
    checks++; if (bus.y !== 4'hF) begin failures++; $display("FAIL latency_early_y: got %h expected %h", bus.y, 4'hF); end
    tick(1);
    checks++; if (bus.y !== 4'hE) begin failures++; $display("FAIL latency_y: got %h expected %h", bus.y, 4'hE); end
    checks++; if (bus.fell !== 4'h1 || bus.rose !== 4'h0) begin failures++; $display("FAIL latency_fell: got fell=%h rose=%h expected fell=1 rose=0", bus.fell, bus.rose); end
    checks++; if (bus.evt_mask !== 4'b0001 || bus.evt_vld !== 1'b1) begin failures++; $display("FAIL latency_evt: got mask=%b vld=%b expected 0001 1", bus.evt_mask, bus.evt_vld); end
    tick(1);
    checks++; if (bus.fell !== 4'h0 || bus.y !== 4'hE) begin failures++; $display("FAIL latency_pulse_end: got fell=%h y=%h expected 0 e", bus.fell, bus.y); end
    ack_pulse();
    checks++; if (bus.evt_mask !== 4'h0 || bus.evt_vld !== 1'b0) begin failures++; $display("FAIL latency_ack: got mask=%b vld=%b expected 0000 0", bus.evt_mask, bus.evt_vld); end
    bus.a[0] = 1'b1;
    tick(LAT);
    checks++; if (bus.rose !== 4'h1 || bus.y !== 4'hF) begin failures++; $display("FAIL latency_rose: got rose=%h y=%h expected 1 f", bus.rose, bus.y); end
    tick(1);
    checks++; if (bus.rose !== 4'h0) begin failures++; $display("FAIL latency_rose_end: got %h expected 0", bus.rose); end
    ack_pulse();
    $display("test_latency done checks=%0d", checks);
  endtask

  task automatic test_glitch();
    int nf, nr, tf, tr;
    bit y_moved;
    nf = 0; nr = 0; y_moved = 1'b0;
    bus.a[1] = 1'b0;
    for (int t = 1; t <= 14; t++) begin
      tick(1);
      if (t == 3) bus.a[1] = 1'b1;
      if (bus.y[1] !== 1'b1) y_moved = 1'b1;
      nf += int'(bus.fell[1]);
      nr += int'(bus.rose[1]);
    end
    checks++; if (y_moved) begin failures++; $display("FAIL glitch3_y: got y[1] moved expected steady 1"); end
    checks++; if (nf != 0 || nr != 0) begin failures++; $display("FAIL glitch3_pulses: got fell=%0d rose=%0d expected 0 0", nf, nr); end
    nf = 0; nr = 0; tf = -1; tr = -1;
    bus.a[1] = 1'b0;
    for (int t = 1; t <= 18; t++) begin
      tick(1);
      if (t == 4) bus.a[1] = 1'b1;
      if (bus.fell[1]) begin nf++; tf = t; end
      if (bus.rose[1]) begin nr++; tr = t; end
    end
    checks++; if (nf != 1 || tf != LAT) begin failures++; $display("FAIL glitch4_fell: got count=%0d at=%0d expected 1 at %0d", nf, tf, LAT); end
    checks++; if (nr != 1 || tr != 4 + LAT) begin failures++; $display("FAIL glitch4_rose: got count=%0d at=%0d expected 1 at %0d", nr, tr, 4 + LAT); end
    checks++; if (bus.evt_ovf !== 1'b1) begin failures++; $display("FAIL glitch4_ovf: got %b expected 1", bus.evt_ovf); end
    ack_pulse();
    checks++; if (bus.evt_ovf !== 1'b0 || bus.evt_mask !== 4'h0) begin failures++; $display("FAIL glitch_ack: got ovf=%b mask=%b expected 0 0000", bus.evt_ovf, bus.evt_mask); end
    $display("test_glitch done checks=%0d", checks);
  endtask

  task automatic test_ack_race();
    bus.a[0] = 1'b0;
    tick(LAT);
    checks++; if (bus.evt_mask !== 4'b0001) begin failures++; $display("FAIL race_setup: got %b expected 0001", bus.evt_mask); end
    bus.a[2] = 1'b0;
    tick(LAT - 1);
    bus.evt_ack = 1'b1;
    tick(1);
    bus.evt_ack = 1'b0;
    checks++; if (bus.y !== 4'b1010) begin failures++; $display("FAIL race_y: got %b expected 1010", bus.y); end
    checks++; if (bus.evt_mask !== 4'b0100 || bus.evt_vld !== 1'b1) begin failures++; $display("FAIL race_mask: got mask=%b vld=%b expected 0100 1", bus.evt_mask, bus.evt_vld); end
    checks++; if (bus.evt_ovf !== 1'b0) begin failures++; $display("FAIL race_ovf: got %b expected 0", bus.evt_ovf); end
    ack_pulse();
    // Acknowledge held high while nothing is pending must not swallow new changes.
    bus.a[0] = 1'b1;
    bus.a[2] = 1'b1;
    bus.evt_ack = 1'b1;
    tick(LAT);
    bus.evt_ack = 1'b0;
    checks++; if (bus.evt_mask !== 4'b0101 || bus.y !== 4'hF) begin failures++; $display("FAIL idle_ack: got mask=%b y=%h expected 0101 f", bus.evt_mask, bus.y); end
    ack_pulse();
    $display("test_ack_race done checks=%0d", checks);
  endtask

  task automatic test_overflow();
    bus.a[3] = 1'b0;
    tick(LAT);
    checks++; if (bus.evt_ovf !== 1'b0) begin failures++; $display("FAIL ovf_first: got %b expected 0", bus.evt_ovf); end
    bus.a[3] = 1'b1;
    tick(LAT);
    checks++; if (bus.evt_ovf !== 1'b1 || bus.evt_mask !== 4'b1000) begin failures++; $display("FAIL ovf_set: got ovf=%b mask=%b expected 1 1000", bus.evt_ovf, bus.evt_mask); end
    ack_pulse();
    checks++; if (bus.evt_ovf !== 1'b0 || bus.evt_mask !== 4'h0 || bus.evt_vld !== 1'b0) begin failures++; $display("FAIL ovf_ack: got ovf=%b mask=%b vld=%b expected 0 0000 0", bus.evt_ovf, bus.evt_mask, bus.evt_vld); end
    $display("test_overflow done checks=%0d", checks);
  endtask

  task automatic test_reset_mid();
    bus.a[0] = 1'b0;
    tick(SYNC + 2);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.y !== 4'hF || bus.fell !== 4'h0) begin failures++; $display("FAIL midrst_y: got y=%h fell=%h expected f 0", bus.y, bus.fell); end
    @(negedge clk);
    rst_n = 1'b1;
    tick(LAT - 1);
    checks++; if (bus.y !== 4'hF || bus.fell !== 4'h0) begin failures++; $display("FAIL midrst_early: got y=%h fell=%h expected f 0", bus.y, bus.fell); end
    tick(1);
    checks++; if (bus.y !== 4'hE || bus.fell !== 4'h1) begin failures++; $display("FAIL midrst_fall: got y=%h fell=%h expected e 1", bus.y, bus.fell); end
    bus.a[0] = 1'b1;
    tick(LAT + 1);
    ack_pulse();
    $display("test_reset_mid done checks=%0d", checks);
  endtask

  task automatic test_random();
    int fails_before;
    fails_before = failures;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if ($urandom_range(5) == 0) bus.a[i] = ~bus.a[i];
      end
      bus.evt_ack = ($urandom_range(3) == 0);
      tick(1);
      checks++; if (bus.y !== m_y) begin failures++; $display("FAIL rand_y cyc%0d: got %h expected %h", c, bus.y, m_y); end
      checks++; if (bus.rose !== m_rose) begin failures++; $display("FAIL rand_rose cyc%0d: got %h expected %h", c, bus.rose, m_rose); end
      checks++; if (bus.fell !== m_fell) begin failures++; $display("FAIL rand_fell cyc%0d: got %h expected %h", c, bus.fell, m_fell); end
      checks++; if (bus.evt_mask !== m_mask) begin failures++; $display("FAIL rand_mask cyc%0d: got %h expected %h", c, bus.evt_mask, m_mask); end
      checks++; if (bus.evt_vld !== (m_mask != '0)) begin failures++; $display("FAIL rand_vld cyc%0d: got %b expected %b", c, bus.evt_vld, (m_mask != '0)); end
      checks++; if (bus.evt_ovf !== m_ovf) begin failures++; $display("FAIL rand_ovf cyc%0d: got %b expected %b", c, bus.evt_ovf, m_ovf); end
      checks++; if ((bus.rose & bus.fell) !== 4'h0) begin failures++; $display("FAIL rand_excl cyc%0d: got %h expected 0", c, bus.rose & bus.fell); end
    end
    bus.evt_ack = 1'b0;
    $display("test_random done checks=%0d new_failures=%0d", checks, failures - fails_before);
  endtask

  initial begin
    bus.a = '1;
    bus.evt_ack = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_glitch();
    test_ack_race();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
